// File: rtl/gl_fetch_stream.sv
// GL command fetch unit: credit-limited BRAM reader, packet-boundary parser and
// prefetch FIFO that streams header and operand words to decode.
module gl_fetch_stream #(
  parameter int          WIDTH      = 32,
  parameter int          ADDR_W     = 32,
  parameter int          TEXT_START = 0,
  parameter int          RD_LAT     = 1,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MULT_HDR   = 32'h8000_1011
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [ADDR_W-1:0] out_hdr_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              dbg_parse_body
);

  // Handshake: a word transfers on every cycle where out_valid && out_ready;
  // while out_valid && !out_ready the out_* fields hold the same FIFO head.

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(TEXT_START);
  localparam logic [WIDTH-1:0]  MULT_WORD  = WIDTH'(MULT_HDR);

  typedef enum logic {S_HDR = 1'b0, S_BODY = 1'b1} parse_t;

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic              sop;
    logic              eop;
    logic [ADDR_W-1:0] hdr;
  } entry_t;

  function automatic logic [4:0] pkt_len(input logic [7:0] op);
    case (op)
      8'h03, 8'h04:                               pkt_len = 5'd4;
      8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h1A, 8'h1B: pkt_len = 5'd17;
      8'h19:                                      pkt_len = 5'd5;
      default:                                    pkt_len = 5'd1;
    endcase
  endfunction

  function automatic logic is_xform(input logic [7:0] op);
    case (op)
      8'h16, 8'h17, 8'h18, 8'h1A, 8'h1B: is_xform = 1'b1;
      default:                           is_xform = 1'b0;
    endcase
  endfunction

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  parse_t            state_q, state_d;
  logic [4:0]        remaining_q, remaining_d;
  logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  entry_t            fifo_mem_q [FIFO_DEPTH];

  logic   ret_valid;
  logic   accept;
  logic   push;
  logic   pop;
  logic   [CW:0] occ;
  entry_t push_entry;
  entry_t head;
  logic   [4:0] len;

  assign ret_valid = vld_q[RD_LAT-1];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign mem_addr  = addr_q;

  // A pop this cycle already counts as free space, so a full FIFO being
  // drained keeps the read stream going without a bubble.
  always_comb begin
    occ       = {1'b0, inflight_q} + {1'b0, count_q} - (CW+1)'(pop);
    mem_rd_en = reset && !flush && (occ < (CW+1)'(FIFO_DEPTH));
  end

  always_comb begin
    addr_d     = flush ? flush_addr : addr_q + ADDR_W'(mem_rd_en);
    vld_d      = RD_LAT'({vld_q, mem_rd_en});
    inflight_d = inflight_q + CW'(mem_rd_en) - CW'(ret_valid);
    drop_d     = drop_q;
    if (flush) begin
      drop_d = inflight_q - CW'(ret_valid);
    end else if (ret_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  // Parser: only words that survive the drop window are decoded.
  always_comb begin
    accept      = reset && ret_valid && (drop_q == '0) && !flush;
    push        = accept;
    push_entry  = '0;
    state_d     = state_q;
    remaining_d = remaining_q;
    hdr_addr_d  = hdr_addr_q;
    ret_addr_d  = ret_addr_q;
    len         = pkt_len(mem_data[7:0]);
    if (accept) begin
      ret_addr_d = ret_addr_q + ADDR_W'(1);
      case (state_q)
        S_HDR: begin
          push_entry.data = is_xform(mem_data[7:0]) ? MULT_WORD : mem_data;
          push_entry.sop  = 1'b1;
          push_entry.eop  = (len == 5'd1);
          push_entry.hdr  = ret_addr_q;
          hdr_addr_d      = ret_addr_q;
          remaining_d     = len - 5'd1;
          if (len != 5'd1) state_d = S_BODY;
        end
        S_BODY: begin
          push_entry.data = mem_data;
          push_entry.sop  = 1'b0;
          push_entry.eop  = (remaining_q == 5'd1);
          push_entry.hdr  = hdr_addr_q;
          remaining_d     = remaining_q - 5'd1;
          if (remaining_q == 5'd1) state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
    if (flush) begin
      state_d    = S_HDR;
      ret_addr_d = flush_addr;
    end
  end

  always_comb begin
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    head         = fifo_mem_q[rd_ptr_q];
    out_data     = '0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    out_hdr_addr = '0;
    if (out_valid) begin
      out_data     = head.data;
      out_sop      = head.sop;
      out_eop      = head.eop;
      out_hdr_addr = head.hdr;
    end
    busy           = (inflight_q != '0) || out_valid;
    dbg_parse_body = (state_q == S_BODY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q      <= START_ADDR;
      ret_addr_q  <= START_ADDR;
      inflight_q  <= '0;
      drop_q      <= '0;
      vld_q       <= '0;
      state_q     <= S_HDR;
      remaining_q <= '0;
      hdr_addr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      addr_q      <= addr_d;
      ret_addr_q  <= ret_addr_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      vld_q       <= vld_d;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      hdr_addr_q  <= hdr_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_gl_fetch_stream.sv
// Bench for gl_fetch_stream: BRAM model with a RD_LAT pipeline, opcode table
// vectors plus hand-written flush/wrap/reset sequences, expected-word queue.
module tb_gl_fetch_stream;

  localparam int          TB_LAT = 3;
  localparam int          AW     = 8;
  localparam int          DW     = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] MHDR   = 32'h8000_1011;
  localparam int          EW     = DW + 2 + AW;

  logic          clk, reset, mem_rd_en, flush;
  logic          out_sop, out_eop, out_valid, out_ready, busy, dbg_parse_body;
  logic [AW-1:0] mem_addr, flush_addr, out_hdr_addr;
  logic [DW-1:0] mem_data, out_data;

  logic [DW-1:0] bram [256];
  logic [DW-1:0] pipe [TB_LAT];
  logic [EW-1:0] exp_q[$];
  int            pass_cnt, tot_cnt;

  typedef struct {
    logic [7:0] op;
    int         len;
    bit         rw;
  } vec_t;
  vec_t tbl[13];

  gl_fetch_stream #(
    .WIDTH(DW), .ADDR_W(AW), .TEXT_START(0), .RD_LAT(TB_LAT),
    .FIFO_DEPTH(DEPTH), .MULT_HDR(MHDR)
  ) dut (
    .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .flush(flush), .flush_addr(flush_addr),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_hdr_addr(out_hdr_addr), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .dbg_parse_body(dbg_parse_body)
  );

  // clock / BRAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= mem_rd_en ? bram[mem_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < TB_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data = pipe[TB_LAT-1];

  function automatic logic [EW-1:0] mk(input logic [DW-1:0] d, input logic s,
                                       input logic e, input logic [AW-1:0] h);
    return {d, s, e, h};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // driver tasks: inputs change at negedge, observation 1ns later
  task automatic tick();
    @(negedge clk); flush = 1'b0; #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    check("rst_rd_en",   64'(mem_rd_en),      64'd0);
    check("rst_addr",    64'(mem_addr),       64'd0);
    check("rst_valid",   64'(out_valid),      64'd0);
    check("rst_data",    64'(out_data),       64'd0);
    check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
    check("rst_hdr",     64'(out_hdr_addr),   64'd0);
    check("rst_busy",    64'(busy),           64'd0);
    check("rst_state",   64'(dbg_parse_body), 64'd0);
    @(negedge clk); reset = 1'b1; #1;
  endtask

  task automatic do_flush(input logic [AW-1:0] a);
    @(negedge clk); flush = 1'b1; flush_addr = a; out_ready = 1'b0; #1;
    check("flush_no_read", 64'(mem_rd_en), 64'd0);
    @(negedge clk); flush = 1'b0; #1;
  endtask

  // scoreboard: pop and compare one expected word per handshake
  task automatic drain(output int gaps);
    int budget = 0;
    int idx = 0;
    bit started = 0;
    logic [EW-1:0] e;
    gaps = 0;
    while (exp_q.size() > 0 && budget < 400) begin
      @(negedge clk); flush = 1'b0; out_ready = 1'b1; #1;
      budget++;
      if (out_valid) begin
        e = exp_q.pop_front();
        check($sformatf("word%0d", idx),
              64'({out_data, out_sop, out_eop, out_hdr_addr}), 64'(e));
        idx++;
        started = 1;
      end else if (started) begin
        gaps++;
      end
    end
    @(negedge clk); out_ready = 1'b0;
    if (exp_q.size() > 0) begin
      tot_cnt++;
      $display("FAIL drain_timeout: %0d words missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int gaps, first_v, rd_cnt, base;
    logic [DW-1:0] hw, ehdr;

    reset = 1'b0; flush = 1'b0; flush_addr = '0; out_ready = 1'b0;
    pass_cnt = 0; tot_cnt = 0;
    for (int i = 0; i < 256; i++) bram[i] = '0;

    tbl[0]  = '{8'h03, 4,  1'b0};
    tbl[1]  = '{8'h04, 4,  1'b0};
    tbl[2]  = '{8'h11, 17, 1'b0};
    tbl[3]  = '{8'h13, 17, 1'b0};
    tbl[4]  = '{8'h16, 17, 1'b1};
    tbl[5]  = '{8'h17, 17, 1'b1};
    tbl[6]  = '{8'h18, 17, 1'b1};
    tbl[7]  = '{8'h1A, 17, 1'b1};
    tbl[8]  = '{8'h1B, 17, 1'b1};
    tbl[9]  = '{8'h19, 5,  1'b0};
    tbl[10] = '{8'h00, 1,  1'b0};
    tbl[11] = '{8'h12, 1,  1'b0};
    tbl[12] = '{8'hFF, 1,  1'b0};

    // reset, latency, backpressure, then drain without gaps
    bram[0] = 32'hABCD_0003; bram[1] = 32'h1234_5611; bram[2] = 32'h5A5A_5A5A;
    bram[3] = 32'h0000_0019; bram[4] = 32'h0000_0000;
    do_reset();
    first_v = out_valid ? 0 : -1;
    rd_cnt  = mem_rd_en ? 1 : 0;
    for (int k = 1; k < 20; k++) begin
      tick();
      if (mem_rd_en) rd_cnt++;
      if (out_valid && first_v < 0) first_v = k;
    end
    check("first_valid_cycle", 64'(first_v), 64'(TB_LAT + 1));
    check("reads_while_stalled", 64'(rd_cnt), 64'(DEPTH));
    check("stalled_valid", 64'(out_valid), 64'd1);
    check("stalled_busy", 64'(busy), 64'd1);
    exp_q.push_back(mk(bram[0], 1, 0, 8'h00));
    exp_q.push_back(mk(bram[1], 0, 0, 8'h00));
    exp_q.push_back(mk(bram[2], 0, 0, 8'h00));
    exp_q.push_back(mk(bram[3], 0, 1, 8'h00));
    exp_q.push_back(mk(bram[4], 1, 1, 8'h04));
    drain(gaps);
    check("drain_gaps", 64'(gaps), 64'd0);

    // table-driven opcode vectors at 0x80
    base = 128;
    for (int i = 0; i < 13; i++) begin
      hw = ($urandom() & 32'hFFFF_FF00) | {24'h0, tbl[i].op};
      bram[base] = hw;
      for (int j = 1; j < tbl[i].len; j++) bram[base + j] = $urandom();
      if (tbl[i].len > 1) bram[base + 1] = ($urandom() & 32'hFFFF_FF00) | 32'h11;
      bram[base + tbl[i].len] = $urandom() & 32'hFFFF_FF00;
      ehdr = tbl[i].rw ? MHDR : hw;
      exp_q.push_back(mk(ehdr, 1, tbl[i].len == 1, 8'(base)));
      for (int j = 1; j < tbl[i].len; j++)
        exp_q.push_back(mk(bram[base + j], 0, j == tbl[i].len - 1, 8'(base)));
      exp_q.push_back(mk(bram[base + tbl[i].len], 1, 1, 8'(base + tbl[i].len)));
      do_flush(8'h80);
      drain(gaps);
    end

    // flush while reads are in flight and the FIFO holds words
    bram[8'h40] = 32'h0000_0004;
    for (int j = 1; j < 4; j++) bram[8'h40 + j] = $urandom();
    bram[8'h44] = 32'h0000_0000;
    do_reset();
    repeat (4) tick();
    check("pre_flush_busy", 64'(busy), 64'd1);
    check("pre_flush_valid", 64'(out_valid), 64'd1);
    do_flush(8'h40);
    for (int j = 0; j < 5; j++)
      exp_q.push_back(mk(bram[8'h40 + j], j == 0 || j == 4, j >= 3, j == 4 ? 8'h44 : 8'h40));
    drain(gaps);

    // second flush inside the drop window of the first
    bram[8'h60] = 32'h0000_001B;
    for (int j = 1; j < 17; j++) bram[8'h60 + j] = $urandom();
    bram[8'h71] = 32'h0000_0000;
    do_reset();
    repeat (4) tick();
    do_flush(8'h40);
    check("resume_rd_en", 64'(mem_rd_en), 64'd1);
    check("resume_addr", 64'(mem_addr), 64'h40);
    do_flush(8'h60);
    exp_q.push_back(mk(MHDR, 1, 0, 8'h60));
    for (int j = 1; j < 17; j++) exp_q.push_back(mk(bram[8'h60 + j], 0, j == 16, 8'h60));
    exp_q.push_back(mk(bram[8'h71], 1, 1, 8'h71));
    drain(gaps);

    // address wrap at 2^ADDR_W-1
    bram[8'hFE] = 32'h0000_0003; bram[8'hFF] = $urandom();
    bram[8'h00] = $urandom();    bram[8'h01] = $urandom(); bram[8'h02] = 32'h0;
    repeat (10) tick();
    do_flush(8'hFE);
    check("wrap_addr0", 64'({mem_rd_en, mem_addr}), 64'h1FE);
    tick();
    check("wrap_addr1", 64'({mem_rd_en, mem_addr}), 64'h1FF);
    tick();
    check("wrap_addr2", 64'({mem_rd_en, mem_addr}), 64'h100);
    exp_q.push_back(mk(bram[8'hFE], 1, 0, 8'hFE));
    exp_q.push_back(mk(bram[8'hFF], 0, 0, 8'hFE));
    exp_q.push_back(mk(bram[8'h00], 0, 0, 8'hFE));
    exp_q.push_back(mk(bram[8'h01], 0, 1, 8'hFE));
    exp_q.push_back(mk(bram[8'h02], 1, 1, 8'h02));
    drain(gaps);

    // reset in the middle of a 17-word packet
    bram[base] = 32'h0000_0011;
    for (int j = 1; j < 17; j++) bram[base + j] = $urandom();
    do_flush(8'h80);
    exp_q.push_back(mk(bram[base], 1, 0, 8'h80));
    for (int j = 1; j < 8; j++) exp_q.push_back(mk(bram[base + j], 0, 0, 8'h80));
    drain(gaps);
    tick();
    check("mid_packet_body", 64'(dbg_parse_body), 64'd1);
    bram[0] = 32'h0000_0019;
    for (int j = 1; j < 5; j++) bram[j] = $urandom();
    bram[5] = 32'h0000_0000;
    do_reset();
    for (int j = 0; j < 5; j++) exp_q.push_back(mk(bram[j], j == 0, j == 4, 8'h00));
    exp_q.push_back(mk(bram[5], 1, 1, 8'h05));
    drain(gaps);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
